// File: rtl/ipg_chunk_arbiter.sv
// ipg_chunk_arbiter: round-robin, burst-limited sharing of the PHY IPG chunk
// insertion port among N_SRC requesters (tx_clk domain).
// Optional feature macro: IPG_ARB_STRICT_PRIO_EN (source 0 becomes strict priority).
//
// state | meaning
// IDLE  | arbitrate among valid sources; no transfer this cycle
// BURST | grant held by grant_id; chunks move whenever slot_avail allows
module ipg_chunk_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int N_SRC      = 4,
  parameter int MAX_BURST  = 4,
  localparam int ID_W      = $clog2(N_SRC)
) (
  input  logic                        tx_clk,
  input  logic                        tx_rst,
  input  logic                        enable,
  input  logic                        slot_avail,
  input  logic [N_SRC*DATA_WIDTH-1:0] src_tdata,
  input  logic [N_SRC-1:0]            src_tvalid,
  output logic [N_SRC-1:0]            src_tready,
  output logic [DATA_WIDTH-1:0]       ipg_req_chunk,
  output logic                        reqq_write,
  output logic                        grant_valid,
  output logic [ID_W-1:0]             grant_id,
  output logic [31:0]                 chunk_count
);

  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                  state_q, state_d;
  logic [ID_W-1:0]         ptr_q, ptr_d;
  logic [ID_W-1:0]         gid_q, gid_d;
  logic [CNT_W-1:0]        burst_cnt_q, burst_cnt_d;
  logic [DATA_WIDTH-1:0]   chunk_q, chunk_d;
  logic                    wr_q, wr_d;
  logic [31:0]             count_q, count_d;

  logic [ID_W-1:0]         pick_id;
  logic                    pick_found;
  logic [ID_W-1:0]         cand;
  logic                    tvalid_g;
  logic [DATA_WIDTH-1:0]   data_g;
  logic                    xfer;
  logic                    burst_end;

  assign tvalid_g = src_tvalid[gid_q];
  assign data_g   = src_tdata[int'(gid_q)*DATA_WIDTH +: DATA_WIDTH];

  // Round-robin search starting just after the last finished grant.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    cand       = '0;
    for (int k = 1; k <= N_SRC; k++) begin
      cand = ID_W'((int'(ptr_q) + k) % N_SRC);
      if (!pick_found && src_tvalid[cand]) begin
        pick_found = 1'b1;
        pick_id    = cand;
      end
    end
`ifdef IPG_ARB_STRICT_PRIO_EN
    if (src_tvalid[0]) begin
      pick_id = '0;
    end
`endif
  end

  // Next-state, transfer and burst-termination logic.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gid_d       = gid_q;
    burst_cnt_d = burst_cnt_q;
    chunk_d     = chunk_q;
    wr_d        = 1'b0;
    count_d     = count_q;
    src_tready  = '0;
    xfer        = 1'b0;
    burst_end   = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable && (|src_tvalid)) begin
          state_d     = BURST;
          gid_d       = pick_id;
          burst_cnt_d = '0;
        end
      end
      BURST: begin
        xfer = enable && slot_avail && tvalid_g;
        src_tready[gid_q] = xfer;
        if (xfer) begin
          chunk_d     = data_g;
          wr_d        = 1'b1;
          count_d     = count_q + 32'd1;
          burst_cnt_d = burst_cnt_q + CNT_W'(1);
        end
`ifdef IPG_ARB_STRICT_PRIO_EN
        // Source 0 bursts run until valid or enable drops; others yield to source 0.
        if (gid_q == '0) begin
          burst_end = 1'b0;
        end else begin
          burst_end = (xfer && (burst_cnt_q == LAST_CNT)) || src_tvalid[0];
        end
`else
        burst_end = xfer && (burst_cnt_q == LAST_CNT);
`endif
        if (burst_end || !tvalid_g || !enable) begin
          state_d = IDLE;
`ifdef IPG_ARB_STRICT_PRIO_EN
          if (gid_q != '0) begin
            ptr_d = gid_q;
          end
`else
          ptr_d = gid_q;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset drops any in-flight chunk.
  always_ff @(posedge tx_clk or posedge tx_rst) begin
    if (tx_rst) begin
      state_q     <= IDLE;
      ptr_q       <= ID_W'(N_SRC - 1);
      gid_q       <= '0;
      burst_cnt_q <= '0;
      chunk_q     <= '0;
      wr_q        <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gid_q       <= gid_d;
      burst_cnt_q <= burst_cnt_d;
      chunk_q     <= chunk_d;
      wr_q        <= wr_d;
      count_q     <= count_d;
    end
  end

  assign ipg_req_chunk = chunk_q;
  assign reqq_write    = wr_q;
  assign grant_valid   = (state_q == BURST);
  assign grant_id      = gid_q;
  assign chunk_count   = count_q;

endmodule
